// File: rtl/leg_instr_writer.sv
// LEG instruction writer: packs decoded instruction fields into an opcode byte
// and streams opcode/arg1/arg2/dest into program RAM at an auto-incrementing address.
module leg_instr_writer #(
  parameter int          UUID      = 0,
  parameter string       NAME      = "",
  parameter logic [7:0]  BASE_ADDR = 8'd0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [3:0] func,
  input  logic       imm_a,
  input  logic       imm_b,
  input  logic       cond,
  input  logic       lsl,
  input  logic       lsr,
  input  logic [7:0] arg1,
  input  logic [7:0] arg2,
  input  logic [7:0] dest,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_data,
  output logic       busy,
  output logic       err,
  output logic [7:0] count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_W0   = 3'd1,
    S_W1   = 3'd2,
    S_W2   = 3'd3,
    S_W3   = 3'd4
  } state_t;

  state_t     r_state;
  logic [7:0] r_ptr;
  logic [7:0] r_count;
  logic [7:0] r_op;
  logic [7:0] r_a1;
  logic [7:0] r_a2;
  logic [7:0] r_dst;
  logic       r_err;

  logic       w_accept;
  logic       w_illegal;
  logic       w_take;

  // Shift requests override the function nibble; bit 4 is always zero.
  function automatic logic [7:0] f_opcode(input logic [3:0] fn, input logic ia,
                                          input logic ib, input logic cd,
                                          input logic sl, input logic sr);
    logic [3:0] nib;
    nib = fn;
    if (sl)
      nib = 4'hA;
    else if (sr)
      nib = 4'hD;
    return {ia, ib, cd, 1'b0, nib};
  endfunction

  assign w_accept  = in_valid & in_ready;
  assign w_illegal = lsl & lsr;
  assign w_take    = w_accept & ~w_illegal;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= BASE_ADDR;
      r_count <= 8'd0;
      r_op    <= 8'd0;
      r_a1    <= 8'd0;
      r_a2    <= 8'd0;
      r_dst   <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      r_err <= w_accept & w_illegal;
      if (w_take) begin
        r_op  <= f_opcode(func, imm_a, imm_b, cond, lsl, lsr);
        r_a1  <= arg1;
        r_a2  <= arg2;
        r_dst <= dest;
      end
      // Every non-idle state writes one byte, so the pointer advances once per state.
      if (r_state != S_IDLE)
        r_ptr <= r_ptr + 8'd1;
      case (r_state)
        S_IDLE: if (w_take) r_state <= S_W0;
        S_W0:   r_state <= S_W1;
        S_W1:   r_state <= S_W2;
        S_W2:   r_state <= S_W3;
        S_W3: begin
          r_count <= r_count + 8'd1;
          r_state <= w_take ? S_W0 : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_data = 8'd0;
    case (r_state)
      S_W0:    mem_data = r_op;
      S_W1:    mem_data = r_a1;
      S_W2:    mem_data = r_a2;
      S_W3:    mem_data = r_dst;
      default: mem_data = 8'd0;
    endcase
  end

  assign in_ready = (r_state == S_IDLE) || (r_state == S_W3);
  assign mem_we   = (r_state != S_IDLE);
  assign busy     = (r_state != S_IDLE);
  assign mem_addr = r_ptr;
  assign err      = r_err;
  assign count    = r_count;

endmodule

// File: tb/tb_leg_instr_writer.sv
// Scoreboard bench for leg_instr_writer: two instances (base 8'h10 and 8'hFE)
// share stimulus; per-instance monitors compare RAM writes against a reference model.
module tb_leg_instr_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       in_valid;
  logic [3:0] func;
  logic       imm_a, imm_b, cond, lsl, lsr;
  logic [7:0] arg1, arg2, dest;

  logic [1:0] rdy, we, bsy, er;
  logic [7:0] addr [2];
  logic [7:0] data [2];
  logic [7:0] cnt  [2];

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] m_ptr [2];
  logic [7:0] m_cnt [2];
  int         m_err [2];

  leg_instr_writer #(.UUID(1), .NAME("w10"), .BASE_ADDR(8'h10)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[0]),
    .func(func), .imm_a(imm_a), .imm_b(imm_b), .cond(cond), .lsl(lsl), .lsr(lsr),
    .arg1(arg1), .arg2(arg2), .dest(dest),
    .mem_we(we[0]), .mem_addr(addr[0]), .mem_data(data[0]),
    .busy(bsy[0]), .err(er[0]), .count(cnt[0]));

  leg_instr_writer #(.UUID(2), .NAME("wFE"), .BASE_ADDR(8'hFE)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy[1]),
    .func(func), .imm_a(imm_a), .imm_b(imm_b), .cond(cond), .lsl(lsl), .lsr(lsr),
    .arg1(arg1), .arg2(arg2), .dest(dest),
    .mem_we(we[1]), .mem_addr(addr[1]), .mem_data(data[1]),
    .busy(bsy[1]), .err(er[1]), .count(cnt[1]));

  function automatic logic [7:0] base_of(input int i);
    return (i == 0) ? 8'h10 : 8'hFE;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_opcode(input logic [3:0] f, input logic ia,
                                            input logic ib, input logic c,
                                            input logic sl, input logic sr);
    int nib;
    nib = sl ? 10 : (sr ? 13 : int'(f));
    return 8'((ia ? 128 : 0) + (ib ? 64 : 0) + (c ? 32 : 0) + nib);
  endfunction

  for (genvar g = 0; g < 2; g++) begin : mon
    logic [15:0] q[$];
    int          idx      = 0;
    int          run      = 0;
    int          last_run = 0;
    int          errs     = 0;
    logic        prev_err = 1'b0;
    always @(negedge clk) begin
      logic [15:0] e;
      chk("busy_eq_we", bsy[g], we[g]);
      if (we[g]) begin
        if (q.size() == 0) begin
          chk("unexpected_write", 1, 0);
        end else begin
          e = q.pop_front();
          chk("wr_addr", addr[g], e[15:8]);
          chk("wr_data", data[g], e[7:0]);
        end
        chk("ready_busy", rdy[g], (idx == 3) ? 1 : 0);
        idx = (idx + 1) % 4;
        run++;
      end else begin
        chk("ready_idle", rdy[g], 1);
        if (run != 0) last_run = run;
        run = 0;
      end
      if (er[g] === 1'b1) begin
        errs++;
        if (prev_err) chk("err_one_cycle", 1, 0);
      end
      prev_err = er[g];
      if (rst) idx = 0;
    end
  end

  task automatic push_exp(input int i, input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    logic [7:0] b [4];
    b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
    for (int k = 0; k < 4; k++) begin
      if (i == 0) mon[0].q.push_back({m_ptr[i], b[k]});
      else        mon[1].q.push_back({m_ptr[i], b[k]});
      m_ptr[i] = m_ptr[i] + 8'd1;
    end
    m_cnt[i] = m_cnt[i] + 8'd1;
  endtask

  // Present an instruction, hold until accepted, then update the model.
  task automatic send(input logic [3:0] f, input logic ia, input logic ib, input logic c,
                      input logic sl, input logic sr,
                      input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] d);
    int t = 0;
    func = f; imm_a = ia; imm_b = ib; cond = c; lsl = sl; lsr = sr;
    arg1 = a1; arg2 = a2; dest = d; in_valid = 1'b1;
    while (!rdy[0] && t < 20) begin
      @(posedge clk); #1; t++;
    end
    if (!rdy[0]) chk("accept_timeout", 0, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++) begin
      if (sl && sr) m_err[i]++;
      else push_exp(i, ref_opcode(f, ia, ib, c, sl, sr), a1, a2, d);
    end
  endtask

  task automatic idle_wait();
    int t = 0;
    in_valid = 1'b0;
    while ((bsy[0] || bsy[1]) && t < 50) begin
      @(posedge clk); #1; t++;
    end
    if (bsy[0] || bsy[1]) chk("drain_timeout", 0, 1);
    @(negedge clk); #1;
  endtask

  task automatic flush_model();
    mon[0].q.delete();
    mon[1].q.delete();
    for (int i = 0; i < 2; i++) begin
      m_ptr[i] = base_of(i);
      m_cnt[i] = 8'd0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    flush_model();
  endtask

  task automatic check_counts(input string nm);
    for (int i = 0; i < 2; i++) begin
      chk({nm, "_count"}, cnt[i], m_cnt[i]);
      chk({nm, "_errs"}, (i == 0) ? mon[0].errs : mon[1].errs, m_err[i]);
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0;
    func = 4'h0; imm_a = 0; imm_b = 0; cond = 0; lsl = 0; lsr = 0;
    arg1 = 0; arg2 = 0; dest = 0;
    m_err[0] = 0; m_err[1] = 0;
    flush_model();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 2; i++) begin
      chk("rst_in_ready", rdy[i], 1);
      chk("rst_mem_we", we[i], 0);
      chk("rst_mem_addr", addr[i], base_of(i));
      chk("rst_mem_data", data[i], 0);
      chk("rst_busy", bsy[i], 0);
      chk("rst_err", er[i], 0);
      chk("rst_count", cnt[i], 0);
    end

    // Basic write; instance 1 straddles the FF->00 wrap.
    send(4'h2, 1, 0, 0, 0, 0, 8'h05, 8'h07, 8'h03);
    idle_wait();
    chk("single_busy_len", mon[0].last_run, 4);
    check_counts("single");

    send(4'h0, 0, 1, 0, 0, 1, 8'h11, 8'h22, 8'h33);
    send(4'h7, 1, 1, 1, 1, 0, 8'h44, 8'h55, 8'h66);
    idle_wait();
    check_counts("shift");

    // Illegal in IDLE: pointer and count hold.
    send(4'h3, 0, 0, 0, 1, 1, 8'hAA, 8'hBB, 8'hCC);
    idle_wait();
    chk("illegal_ptr0", addr[0], m_ptr[0]);
    chk("illegal_ptr1", addr[1], m_ptr[1]);
    check_counts("illegal_idle");
    send(4'h1, 0, 0, 1, 0, 0, 8'h01, 8'h02, 8'h03);
    idle_wait();
    check_counts("after_illegal");

    // Back-to-back: 12 consecutive writes.
    send(4'h4, 0, 0, 0, 0, 0, 8'h10, 8'h20, 8'h30);
    send(4'h5, 1, 0, 1, 0, 0, 8'h40, 8'h50, 8'h60);
    send(4'h6, 0, 1, 0, 0, 1, 8'h70, 8'h80, 8'h90);
    idle_wait();
    chk("b2b_run_len", mon[0].last_run, 12);
    check_counts("b2b");

    // Illegal accepted in W3 coincides with the count increment.
    send(4'h8, 0, 0, 0, 0, 0, 8'hDE, 8'hAD, 8'hBE);
    send(4'h9, 1, 1, 0, 1, 1, 8'hEF, 8'h00, 8'h01);
    idle_wait();
    check_counts("illegal_w3");

    // Reset during W1 aborts the sequence.
    send(4'hB, 0, 0, 0, 0, 0, 8'h12, 8'h34, 8'h56);
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    flush_model();
    for (int i = 0; i < 2; i++) begin
      chk("abort_mem_we", we[i], 0);
      chk("abort_mem_addr", addr[i], base_of(i));
      chk("abort_count", cnt[i], 0);
      chk("abort_in_ready", rdy[i], 1);
    end
    send(4'hC, 1, 0, 0, 0, 0, 8'h9A, 8'hBC, 8'hDE);
    idle_wait();
    check_counts("post_abort");

    // Randomized traffic with gaps and occasional illegal requests.
    for (int n = 0; n < 60; n++) begin
      logic sl, sr;
      sl = ($urandom_range(0, 3) == 0);
      sr = ($urandom_range(0, 3) == 0);
      send(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), sl, sr,
           8'($urandom), 8'($urandom), 8'($urandom));
      in_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end
    idle_wait();
    check_counts("random");

    // 256 instructions wrap the count back to zero.
    do_reset();
    for (int n = 0; n < 256; n++)
      send(4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'($urandom),
           8'($urandom), 8'($urandom), 8'($urandom));
    idle_wait();
    chk("wrap_count0", cnt[0], 0);
    chk("wrap_count1", cnt[1], 0);
    chk("wrap_ptr0", addr[0], m_ptr[0]);
    chk("wrap_ptr1", addr[1], m_ptr[1]);

    chk("q0_empty", mon[0].q.size(), 0);
    chk("q1_empty", mon[1].q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/leg_instr_writer.md
# leg_instr_writer

Encoder-side counterpart to the LEG opcode decode path. It accepts one instruction as discrete fields (ALU function, immediate-A/B flags, condition flag, shift request, two operands, destination) over a valid/ready handshake. It assembles the 8-bit opcode byte with the same bit layout the decoder expects. It then streams the 4-byte instruction (opcode, arg1, arg2, dest) into program memory one byte per cycle at an auto-incrementing address. It sits between the test/loader front end and the program RAM write port.

## Interface
Parameters:
- UUID, 0, component instance identifier (XORed into child UUIDs)
- NAME, "", display name
- BASE_ADDR, 8'd0, program address loaded into the write pointer on reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  instruction fields valid
- in_ready  out  1  block can accept an instruction this cycle
- func  in  4  ALU/function code (opcode[3:0])
- imm_a  in  1  arg1 is immediate (opcode[7])
- imm_b  in  1  arg2 is immediate (opcode[6])
- cond  in  1  conditional/jump group (opcode[5])
- lsl  in  1  request logical shift left; forces func = 4'hA
- lsr  in  1  request logical shift right; forces func = 4'hD
- arg1, arg2, dest  in  8 each  operand/destination bytes
- mem_we  out  1  program RAM write enable
- mem_addr  out  8  program RAM byte address
- mem_data  out  8  program RAM write data
- busy  out  1  write sequence in progress
- err  out  1  one-cycle pulse: rejected instruction
- count  out  8  instructions written since reset, wraps 255→0

## Operation
- Opcode = {imm_a, imm_b, cond, 1'b0, f}. f = 4'hA if lsl, 4'hD if lsr, else func. imm_a=imm_b=1 is legal ("IMMALL").
- lsl and lsr both set is illegal. The handshake completes and fields are dropped. Nothing is written. err pulses. The pointer and count are unchanged.
- Accept = in_valid & in_ready. All fields are latched into internal registers on accept, so inputs may change afterwards.
- FSM states: IDLE, W0, W1, W2, W3.
  - IDLE: in_ready=1. Legal accept → W0. Illegal accept → IDLE.
  - W0: write opcode. W1: write arg1. W2: write arg2. W3: write dest.
  - W3: in_ready=1 and count increments. Legal accept → W0 (back-to-back). Illegal accept or no accept → IDLE.
  - W0–W2: in_ready=0.
- Outputs are Moore-style, decoded from state and registers.
  - mem_we=1 in W0–W3 only.
  - mem_data is the byte for the current state.
  - mem_addr = write pointer.
  - busy=1 in W0–W3.
- Write pointer: 8-bit. Increments by 1 after every written byte. Wraps 8'hFF→8'h00 with no flag.
- An instruction may straddle the wrap: bytes at FE, FF, 00, 01.
- The count increment in W3 and err for a rejected accept in W3 can occur in the same cycle. Both take effect.

## Timing
- Reset values: state IDLE, in_ready=1, mem_we=0, mem_addr=BASE_ADDR, mem_data=0, busy=0, err=0, count=0, latched fields 0.
- rst during W0–W3 aborts the sequence. The next cycle is IDLE with no further mem_we, the pointer is reloaded to BASE_ADDR and count is cleared. A partially written instruction is not rolled back.
- rst has priority over accept in the same cycle.
- Accept at edge N → mem_we high in cycles N+1..N+4 (opcode, arg1, arg2, dest).
- Sustained throughput: 4 cycles per instruction with in_valid held high and fields updated on each accept.
- err is high for exactly the cycle after a rejected accept.
- count updates on the edge leaving W3.

## Test plan
- Reset, BASE_ADDR=8'h10. Accept func=4'h2, imm_a=1, arg1=8'h05, arg2=8'h07, dest=8'h03 → writes (10:82),(11:05),(12:07),(13:03). count=1, busy high 4 cycles.
- lsr=1, func=4'h0, imm_b=1 → opcode 8'h4D. lsl=1, imm_a=imm_b=1, cond=1 → opcode 8'hEA.
- lsl=lsr=1 in IDLE → err one cycle, no mem_we, pointer and count unchanged. Next legal instruction writes at the unchanged address.
- in_valid held high with 3 different instructions → 12 consecutive mem_we cycles, no gaps, addresses contiguous, count=3. in_ready high only in IDLE/W3.
- Pointer preset to 8'hFE via BASE_ADDR → bytes at FE, FF, 00, 01. 256 instructions → count wraps to 0.
- rst asserted in W1 → next cycle mem_we=0, mem_addr=BASE_ADDR, count=0. in_ready=1 and a new accept works normally.
